bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Arbiter for the shared system bus (addr_bus, data_bus, rd_bus, wr_bus, data_mask_bus, fc_bus) between up to NUM_MASTERS requesters, e.g. cpu (master 0) and DMA/debug masters.
- Grants bus ownership with the bus_req/bus_grant handshake the cpu already uses: owner keeps bus_req high for the whole transfer and drops it after fc_bus.
- Fair round-robin arbitration with a turnaround gap between owners so tristate data_bus drivers never overlap.
- Optional watchdog completes hung transfers.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- TURNAROUND, 1, idle cycles between one grant falling and the next rising (0..3).
- TIMEOUT_CYCLES, 256, cycles rd_bus/wr_bus may stay high without fc_bus before watchdog fires (used only with macro).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- bus_req  in  NUM_MASTERS  per-master request, bit i = master i.
- bus_grant  out  NUM_MASTERS  one-hot-or-zero grant, registered.
- grant_id  out  $clog2(NUM_MASTERS)  index of current owner; valid while bus_busy.
- bus_busy  out  1  high while any grant asserted.
- rd_bus  in  1  bus read strobe (monitored).
- wr_bus  in  1  bus write strobe (monitored).
- fc_bus  in  1  slave function-complete (monitored).
- timeout_fc  out  1  watchdog-generated completion, ORed into fc_bus at system level.
- timeout_err  out  1  sticky error flag.
- timeout_id  out  $clog2(NUM_MASTERS)  owner at time of timeout.

Behaviour:
- Reset (rst=0, async): bus_grant=0, grant_id=0, bus_busy=0, timeout_fc=0, timeout_err=0, timeout_id=0, state=IDLE, rr pointer=0 (master 0 highest priority first). Grants drop immediately, not at the next edge, even mid-transfer.
- State machine IDLE / GRANT / GAP.
- IDLE: if any bus_req bit high at a rising edge, pick winner and go GRANT. Winner's bus_grant bit rises on that same edge, so latency is 1 cycle from request sampled.
- Winner: first asserted bit searching from (last_owner+1) mod NUM_MASTERS upward with wrap. After reset, search starts at 0.
- GRANT: grant held while bus_req[owner]=1; other requests ignored (no preemption). When bus_req[owner] is sampled 0, bus_grant clears on that edge and last_owner updates.
  - TURNAROUND>0: go GAP.
  - TURNAROUND=0: go IDLE.
- GAP: counts TURNAROUND cycles with bus_grant=0, then IDLE. Requests arriving during GAP are held off and arbitrated in IDLE.
- Minimum cycles between owner A's grant falling and owner B's grant rising is TURNAROUND+1.
- Master dropping and re-raising bus_req in the same GAP gets lowest priority if others wait.
- bus_req of non-owners may toggle freely; only levels sampled in IDLE matter.
- Simultaneous: owner drops req on the same edge another raises it. Release takes precedence; newcomer waits for IDLE.
- NUM_MASTERS=1: degenerates to req/grant with turnaround; rr pointer unused.

Optional Feature:
- Macro BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - In GRANT, counter increments each cycle (rd_bus|wr_bus)=1 and fc_bus=0; clears when fc_bus=1, when rd_bus and wr_bus are both 0, or on a grant change.
  - Counter reaching TIMEOUT_CYCLES: timeout_fc=1, timeout_err=1, timeout_id=grant_id.
  - timeout_fc stays 1 until rd_bus and wr_bus both sampled 0, then clears.
  - timeout_err clears only on reset.
- Undefined: counter not built; timeout_fc, timeout_err and timeout_id tied 0.

Test Plan:
- Reset: rst=0 pulse with bus_req=2'b11 -> all outputs 0 during reset. First edge after release grants master 0: bus_grant=2'b01, grant_id=0, bus_busy=1.
- Single master: cpu raises bus_req[0], drops it 3 cycles after grant -> grant rises 1 cycle after req, falls on the edge req sampled low, then 1 GAP cycle, then IDLE.
- Round-robin: bus_req=2'b11 held, each owner releases after 2 cycles -> grants alternate 01,00,10,00,01. Never two bits set; gap ≥1 cycle.
- No preemption: master 0 owns, master 1 raises req mid-transfer -> bus_grant stays 01 until master 0 drops req, then 10 after TURNAROUND+1 cycles.
- Reset mid-transfer: rst=0 while bus_grant=10 -> bus_grant=00 asynchronously before next clk edge. After release, arbitration restarts at master 0.
- With BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8: master 1 holds rd_bus=1, fc_bus=0 -> timeout_fc=1, timeout_err=1, timeout_id=1 after 8 cycles. timeout_fc clears once rd_bus=0; timeout_err stays 1.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for the shared system bus with a turnaround gap between owners.
// Optional transfer watchdog is built when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int TURNAROUND     = 1,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int ID_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] bus_req,
   output logic [NUM_MASTERS-1:0] bus_grant,
   output logic [ID_W-1:0]        grant_id,
   output logic                   bus_busy,
   input  logic                   rd_bus,
   input  logic                   wr_bus,
   input  logic                   fc_bus,
   output logic                   timeout_fc,
   output logic                   timeout_err,
   output logic [ID_W-1:0]        timeout_id
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_GRANT = 2'b01;
   localparam logic [1:0] ST_GAP   = 2'b10;

   localparam logic [1:0]             GAP_LAST  = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;
   localparam logic [NUM_MASTERS-1:0] GRANT_ONE = NUM_MASTERS'(1'b1);

   logic [1:0]             state_r;
   logic [1:0]             gap_cnt_r;
   logic [ID_W-1:0]        rr_ptr_r;
   logic [NUM_MASTERS-1:0] bus_grant_r;
   logic [ID_W-1:0]        grant_id_r;
   logic                   bus_busy_r;

   logic [ID_W-1:0]        winner_s;
   logic                   found_s;
   logic [ID_W-1:0]        idx_s;
   logic [ID_W-1:0]        next_ptr_s;
   logic                   owner_req_s;

   assign bus_grant   = bus_grant_r;
   assign grant_id    = grant_id_r;
   assign bus_busy    = bus_busy_r;
   assign owner_req_s = bus_req[grant_id_r];

   // Round-robin search: first requester at or after rr_ptr_r, wrapping around.
   always_comb begin
      winner_s = '0;
      found_s  = 1'b0;
      idx_s    = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         idx_s = ID_W'((int'(rr_ptr_r) + i) % NUM_MASTERS);
         if (!found_s && bus_req[idx_s]) begin
            winner_s = idx_s;
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
   end

   // Search start after the current owner releases: the master just above it.
   always_comb begin
      if (grant_id_r == ID_W'(NUM_MASTERS - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_id_r + ID_W'(1);
      end
   end

   // Arbitration FSM; reset drops the grant asynchronously even mid-transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         gap_cnt_r   <= 2'd0;
         rr_ptr_r    <= '0;
         bus_grant_r <= '0;
         grant_id_r  <= '0;
         bus_busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  bus_grant_r <= GRANT_ONE << winner_s;
                  grant_id_r  <= winner_s;
                  bus_busy_r  <= 1'b1;
                  state_r     <= ST_GRANT;
               end else begin
                  state_r     <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               // No preemption: only the owner's own request level matters here.
               if (!owner_req_s) begin
                  bus_grant_r <= '0;
                  bus_busy_r  <= 1'b0;
                  rr_ptr_r    <= next_ptr_s;
                  gap_cnt_r   <= 2'd0;
                  state_r     <= (TURNAROUND > 0) ? ST_GAP : ST_IDLE;
               end else begin
                  state_r     <= ST_GRANT;
               end
            end
            ST_GAP: begin
               if (gap_cnt_r == GAP_LAST) begin
                  state_r   <= ST_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + 2'd1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               bus_grant_r <= '0;
               bus_busy_r  <= 1'b0;
            end
         endcase
      end
   end

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam int            TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

   logic [TO_W-1:0] to_cnt_r;
   logic            to_fc_r;
   logic            to_err_r;
   logic [ID_W-1:0] to_id_r;
   logic            strobe_s;
   logic            count_en_s;

   assign strobe_s    = rd_bus | wr_bus;
   assign count_en_s  = (state_r == ST_GRANT) && owner_req_s && strobe_s && !fc_bus;
   assign timeout_fc  = to_fc_r;
   assign timeout_err = to_err_r;
   assign timeout_id  = to_id_r;

   // Watchdog: counts strobe cycles without completion; the release cycle clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt_r <= '0;
         to_fc_r  <= 1'b0;
         to_err_r <= 1'b0;
         to_id_r  <= '0;
      end else begin
         if (!count_en_s) begin
            to_cnt_r <= '0;
         end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
         end else begin
            to_cnt_r <= to_cnt_r;
         end
         if (count_en_s && (to_cnt_r == TO_MAX - TO_W'(1)) && !to_fc_r) begin
            to_fc_r  <= 1'b1;
            to_err_r <= 1'b1;
            to_id_r  <= grant_id_r;
         end else if (!strobe_s) begin
            to_fc_r  <= 1'b0;
         end else begin
            to_fc_r  <= to_fc_r;
         end
      end
   end
`else
   logic unused_strobes_s;
   assign unused_strobes_s = rd_bus ^ wr_bus ^ fc_bus;
   assign timeout_fc       = 1'b0;
   assign timeout_err      = 1'b0;
   assign timeout_id       = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table for round-robin/gap behaviour plus
// hand sequences for reset, mid-transfer reset and the watchdog.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] bus_req;
   logic [1:0] bus_grant;
   logic       grant_id;
   logic       bus_busy;
   logic       rd_bus;
   logic       wr_bus;
   logic       fc_bus;
   logic       timeout_fc;
   logic       timeout_err;
   logic       timeout_id;

   int checks = 0;
   int errors = 0;

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam logic EXP_TO = 1'b1;
`else
   localparam logic EXP_TO = 1'b0;
`endif

   typedef struct {
      logic [1:0] req;
      logic [1:0] grant;
      logic       id;
      logic       busy;
   } vec_t;

   vec_t vecs[18];

   always #5 clk = ~clk;

   bus_arbiter #(
      .NUM_MASTERS(2),
      .TURNAROUND(1),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus_req(bus_req),
      .bus_grant(bus_grant),
      .grant_id(grant_id),
      .bus_busy(bus_busy),
      .rd_bus(rd_bus),
      .wr_bus(wr_bus),
      .fc_bus(fc_bus),
      .timeout_fc(timeout_fc),
      .timeout_err(timeout_err),
      .timeout_id(timeout_id)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, ".grant"}, 32'(bus_grant), 32'd0);
      check({name, ".id"}, 32'(grant_id), 32'd0);
      check({name, ".busy"}, 32'(bus_busy), 32'd0);
      check({name, ".to_fc"}, 32'(timeout_fc), 32'd0);
      check({name, ".to_err"}, 32'(timeout_err), 32'd0);
      check({name, ".to_id"}, 32'(timeout_id), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst     = 1'b0;
      bus_req = 2'b11;
      rd_bus  = 1'b0;
      wr_bus  = 1'b0;
      fc_bus  = 1'b0;

      // req, grant, id, busy (values after the edge where req is sampled)
      vecs[0]  = '{2'b11, 2'b01, 1'b0, 1'b1};
      vecs[1]  = '{2'b11, 2'b01, 1'b0, 1'b1};
      vecs[2]  = '{2'b10, 2'b00, 1'b0, 1'b0};
      vecs[3]  = '{2'b11, 2'b00, 1'b0, 1'b0};
      vecs[4]  = '{2'b11, 2'b10, 1'b1, 1'b1};
      vecs[5]  = '{2'b11, 2'b10, 1'b1, 1'b1};
      vecs[6]  = '{2'b01, 2'b00, 1'b0, 1'b0};
      vecs[7]  = '{2'b01, 2'b00, 1'b0, 1'b0};
      vecs[8]  = '{2'b01, 2'b01, 1'b0, 1'b1};
      vecs[9]  = '{2'b00, 2'b00, 1'b0, 1'b0};
      vecs[10] = '{2'b00, 2'b00, 1'b0, 1'b0};
      vecs[11] = '{2'b01, 2'b01, 1'b0, 1'b1};
      vecs[12] = '{2'b11, 2'b01, 1'b0, 1'b1};
      vecs[13] = '{2'b10, 2'b00, 1'b0, 1'b0};
      vecs[14] = '{2'b10, 2'b00, 1'b0, 1'b0};
      vecs[15] = '{2'b10, 2'b10, 1'b1, 1'b1};
      vecs[16] = '{2'b00, 2'b00, 1'b0, 1'b0};
      vecs[17] = '{2'b00, 2'b00, 1'b0, 1'b0};

      // Reset held across edges with both requests up: everything stays low.
      #1;
      check_idle_outputs("rst_t0");
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("rst_held");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst.grant", 32'(bus_grant), 32'h1);
      check("post_rst.id", 32'(grant_id), 32'd0);
      check("post_rst.busy", 32'(bus_busy), 32'd1);

      bus_req = 2'b00;
      do_reset();

      for (int v = 0; v < 18; v++) begin
         bus_req = vecs[v].req;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d.grant", v), 32'(bus_grant), 32'(vecs[v].grant));
         check($sformatf("vec%0d.busy", v), 32'(bus_busy), 32'(vecs[v].busy));
         if (vecs[v].busy) begin
            check($sformatf("vec%0d.id", v), 32'(grant_id), 32'(vecs[v].id));
         end
         check($sformatf("vec%0d.onehot", v), 32'(bus_grant == 2'b11), 32'd0);
         check($sformatf("vec%0d.to_fc", v), 32'(timeout_fc), 32'd0);
      end

      // Reset mid-transfer: grant must drop before the next clock edge.
      bus_req = 2'b10;
      @(posedge clk);
      #1;
      check("mid.grant_before", 32'(bus_grant), 32'h2);
      #2;
      rst     = 1'b0;
      bus_req = 2'b11;
      #1;
      check("mid.grant_async", 32'(bus_grant), 32'd0);
      check("mid.busy_async", 32'(bus_busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid.restart_grant", 32'(bus_grant), 32'h1);
      check("mid.restart_id", 32'(grant_id), 32'd0);

      // Watchdog: master 1 holds a read with no completion.
      bus_req = 2'b00;
      do_reset();
      bus_req = 2'b10;
      @(posedge clk);
      #1;
      check("to.grant", 32'(bus_grant), 32'h2);
      rd_bus = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      check("to.fc_early", 32'(timeout_fc), 32'd0);
      check("to.err_early", 32'(timeout_err), 32'd0);
      @(posedge clk);
      #1;
      check("to.fc_fire", 32'(timeout_fc), 32'(EXP_TO));
      check("to.err_fire", 32'(timeout_err), 32'(EXP_TO));
      check("to.id_fire", 32'(timeout_id), 32'(EXP_TO));
      check("to.grant_held", 32'(bus_grant), 32'h2);
      rd_bus = 1'b0;
      @(posedge clk);
      #1;
      check("to.fc_clear", 32'(timeout_fc), 32'd0);
      check("to.err_sticky", 32'(timeout_err), 32'(EXP_TO));
      bus_req = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      check("to.err_still", 32'(timeout_err), 32'(EXP_TO));
      check("to.released", 32'(bus_grant), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
